// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: control-bit positions, the EX/MEM entry layout,
// occupancy states and the x0 write-enable mask.
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int RA_W = 5;

  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_READ   = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_MEM_TO_REG = 3;
  localparam int CTL_BRANCH     = 4;
  localparam int CTL_W          = 5;

  typedef struct packed {
    logic              br_taken;
    logic [XLEN-1:0]   r;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   target;
    logic [RA_W-1:0]   rd;
    logic [CTL_W-1:0]  ctl;
  } ex_mem_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_state_t;

  // Writes to x0 are architecturally discarded, so drop reg_write at capture.
  function automatic logic [CTL_W-1:0] x0_mask(input logic [CTL_W-1:0] ctl,
                                               input logic [RA_W-1:0]  rd);
    logic [CTL_W-1:0] m;
    m = ctl;
    if (rd == '0) m[CTL_REG_WRITE] = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM handshake bundle: upstream valid/ready plus entry fields, downstream
// valid/ready plus registered entry. master drives the stage inputs, slave is the stage.
interface ex_mem_stage_if #(
  parameter int WORDSIZE = 64,
  parameter int REGADDR  = 5
) ();
  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] in_r;
  logic                in_z;
  logic [WORDSIZE-1:0] in_store_data;
  logic [WORDSIZE-1:0] in_target;
  logic [REGADDR-1:0]  in_rd;
  logic [4:0]          in_ctl;

  logic                out_valid;
  logic                out_ready;
  logic [WORDSIZE-1:0] out_r;
  logic [WORDSIZE-1:0] out_store_data;
  logic [REGADDR-1:0]  out_rd;
  logic [4:0]          out_ctl;
  logic                out_br_taken;
  logic [WORDSIZE-1:0] out_br_target;

  modport master (
    output in_valid, in_r, in_z, in_store_data, in_target, in_rd, in_ctl, out_ready,
    input  in_ready, out_valid, out_r, out_store_data, out_rd, out_ctl,
           out_br_taken, out_br_target
  );

  modport slave (
    input  in_valid, in_r, in_z, in_store_data, in_target, in_rd, in_ctl, out_ready,
    output in_ready, out_valid, out_r, out_store_data, out_rd, out_ctl,
           out_br_taken, out_br_target
  );
endinterface

// File: rtl/ex_mem_stage_entry_reg.sv
// Loadable entry register: full clear (reset) beats branch-flag clear (flush) beats load.
module ex_mem_entry_reg
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          i_clear,
  input  logic          i_clear_br,
  input  logic          i_load,
  input  ex_mem_entry_t i_d,
  output ex_mem_entry_t o_q
);
  ex_mem_entry_t r_q;

  always_ff @(posedge clk) begin
    if (i_clear)         r_q          <= '0;
    else if (i_clear_br) r_q.br_taken <= 1'b0;
    else if (i_load)     r_q          <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready, flush and branch resolution.
// Build option EX_MEM_SKID_EN adds a skid slot so in_ready becomes a registered output.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int REGADDR  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  ex_mem_stage_if.slave bus
);
  ex_mem_entry_t w_in_entry;
  ex_mem_entry_t w_out_d;
  ex_mem_entry_t w_out_q;
  logic          w_out_load;
  logic          w_in_ready;
  logic          w_acc;
  logic          w_drain;
  logic          r_out_valid;

  always_comb begin
    w_in_entry            = '0;
    w_in_entry.r          = XLEN'(bus.in_r);
    w_in_entry.store_data = XLEN'(bus.in_store_data);
    w_in_entry.target     = XLEN'(bus.in_target);
    w_in_entry.rd         = RA_W'(bus.in_rd);
    w_in_entry.ctl        = x0_mask(bus.in_ctl, RA_W'(bus.in_rd));
    w_in_entry.br_taken   = bus.in_ctl[CTL_BRANCH] & bus.in_z;
  end

  assign w_acc   = bus.in_valid & w_in_ready;
  assign w_drain = r_out_valid & bus.out_ready;

`ifdef EX_MEM_SKID_EN
  occ_state_t    r_state;
  occ_state_t    w_nxt;
  logic          r_in_ready;
  logic          w_skid_load;
  ex_mem_entry_t w_skid_q;

  assign w_in_ready = r_in_ready;

  // Skid slot fills only when the output is stalled; it refills the output on drain.
  always_comb begin
    w_nxt       = r_state;
    w_out_load  = 1'b0;
    w_skid_load = 1'b0;
    w_out_d     = w_in_entry;
    case (r_state)
      OCC_EMPTY: if (w_acc) begin
        w_out_load = 1'b1;
        w_nxt      = OCC_FULL;
      end
      OCC_FULL: begin
        if (w_acc && w_drain) w_out_load = 1'b1;
        else if (w_acc) begin
          w_skid_load = 1'b1;
          w_nxt       = OCC_SKID;
        end else if (w_drain) w_nxt = OCC_EMPTY;
      end
      OCC_SKID: if (w_drain) begin
        w_out_load = 1'b1;
        w_out_d    = w_skid_q;
        w_nxt      = OCC_FULL;
      end
      default: w_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= OCC_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_nxt;
      r_out_valid <= (w_nxt != OCC_EMPTY);
      r_in_ready  <= (w_nxt != OCC_SKID);
    end
  end

  ex_mem_entry_reg u_skid (
    .clk        (clk),
    .i_clear    (rst),
    .i_clear_br (flush),
    .i_load     (w_skid_load),
    .i_d        (w_in_entry),
    .o_q        (w_skid_q)
  );
`else
  assign w_in_ready = !r_out_valid | bus.out_ready;
  assign w_out_load = w_acc;
  assign w_out_d    = w_in_entry;

  always_ff @(posedge clk) begin
    if (rst || flush) r_out_valid <= 1'b0;
    else if (w_acc)   r_out_valid <= 1'b1;
    else if (w_drain) r_out_valid <= 1'b0;
  end
`endif

  ex_mem_entry_reg u_out (
    .clk        (clk),
    .i_clear    (rst),
    .i_clear_br (flush),
    .i_load     (w_out_load),
    .i_d        (w_out_d),
    .o_q        (w_out_q)
  );

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_r          = WORDSIZE'(w_out_q.r);
  assign bus.out_store_data = WORDSIZE'(w_out_q.store_data);
  assign bus.out_br_target  = WORDSIZE'(w_out_q.target);
  assign bus.out_rd         = REGADDR'(w_out_q.rd);
  assign bus.out_ctl        = w_out_q.ctl;
  assign bus.out_br_taken   = w_out_q.br_taken;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage; follows EX_MEM_SKID_EN to pick the expected ready rule.
module tb_ex_mem_stage;
  localparam int EW = 203;
  localparam logic [63:0] TGT_XOR = 64'h8000_0000_0000_1000;
`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;

  ex_mem_stage_if #(.WORDSIZE(64), .REGADDR(5)) bus ();

  ex_mem_stage #(.WORDSIZE(64), .REGADDR(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] sb_q[$];
  bit m_live  = 1'b0;
  bit m_zero  = 1'b0;
  bit m_brclr = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] exp_entry();
    logic [4:0] c;
    c = bus.in_ctl;
    if (bus.in_rd == 5'd0) c[0] = 1'b0;
    return {bus.in_ctl[4] & bus.in_z, bus.in_r, bus.in_store_data, bus.in_target, bus.in_rd, c};
  endfunction

  function automatic logic [EW-1:0] obs_entry();
    return {bus.out_br_taken, bus.out_r, bus.out_store_data, bus.out_br_target,
            bus.out_rd, bus.out_ctl};
  endfunction

  task automatic set_data(input logic [63:0] r, input logic z, input logic [4:0] rd,
                          input logic [4:0] ctl);
    bus.in_r          = r;
    bus.in_z          = z;
    bus.in_store_data = ~r;
    bus.in_target     = r ^ TGT_XOR;
    bus.in_rd         = rd;
    bus.in_ctl        = ctl;
  endtask

  // One clock: drive, check current outputs against the model, advance the model.
  task automatic step(input logic v, input logic ordy, input logic fl, input logic rs,
                      output logic seen_acc);
    logic exp_rdy;
    logic acc;
    logic drn;
    logic [EW-1:0] e;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    flush         = fl;
    rst           = rs;
    #1;
    exp_rdy  = SKID ? (sb_q.size() < 2) : (sb_q.size() == 0 || ordy);
    seen_acc = v & bus.in_ready;
    if (m_live) begin
      check_eq("in_ready", bus.in_ready, exp_rdy);
      check_eq("out_valid", bus.out_valid, sb_q.size() > 0);
      if (sb_q.size() > 0)  check_eq("entry", obs_entry(), sb_q[0]);
      else if (m_zero)      check_eq("rst_zero", obs_entry(), '0);
      else if (m_brclr)     check_eq("br_clear", bus.out_br_taken, 1'b0);
    end
    acc = m_live & v & exp_rdy;
    drn = (sb_q.size() > 0) & ordy;
    e   = exp_entry();
    @(posedge clk);
    if (rs) begin
      sb_q.delete();
      m_live = 1'b1; m_zero = 1'b1; m_brclr = 1'b1;
    end else if (fl) begin
      sb_q.delete();
      m_brclr = 1'b1;
    end else begin
      if (drn) void'(sb_q.pop_front());
      if (acc) begin
        sb_q.push_back(e);
        m_zero = 1'b0; m_brclr = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic sa;
    int   acc_cnt;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0; rst = 1'b0;
    set_data(64'h0, 1'b0, 5'd0, 5'd0);
    @(posedge clk); #1;

    // Reset and idle
    step(0, 1, 0, 1, sa);
    step(0, 1, 0, 1, sa);
    step(0, 1, 0, 0, sa);
    check_eq("t1_out_r", bus.out_r, 64'h0);
    check_eq("t1_in_ready", bus.in_ready, 1'b1);

    // Single entry, then a streamed burst
    set_data(64'h10, 1'b0, 5'd3, 5'b00001);
    step(1, 1, 0, 0, sa);
    check_eq("t2_valid", bus.out_valid, 1'b1);
    check_eq("t2_r", bus.out_r, 64'h10);
    check_eq("t2_rd", bus.out_rd, 5'd3);
    check_eq("t2_ctl", bus.out_ctl, 5'b00001);
    for (int i = 0; i < 8; i++) begin
      set_data(64'h100 + 64'(i), 1'b0, 5'(i + 1), 5'b01011);
      step(1, 1, 0, 0, sa);
    end
    step(0, 1, 0, 0, sa);

    // Branch resolution and x0 masking
    set_data(64'h2000, 1'b1, 5'd7, 5'b10000);
    step(1, 1, 0, 0, sa);
    check_eq("t3_br_taken", bus.out_br_taken, 1'b1);
    check_eq("t3_br_target", bus.out_br_target, 64'h2000 ^ TGT_XOR);
    set_data(64'h2004, 1'b0, 5'd7, 5'b10000);
    step(1, 1, 0, 0, sa);
    check_eq("t3_br_not", bus.out_br_taken, 1'b0);
    set_data(64'h2008, 1'b1, 5'd0, 5'b00001);
    step(1, 1, 0, 0, sa);
    check_eq("t3_x0_ctl", bus.out_ctl, 5'b00000);
    check_eq("t3_nobr", bus.out_br_taken, 1'b0);

    // Stall with upstream still offering entries
    set_data(64'h3000, 1'b0, 5'd9, 5'b00101);
    step(1, 1, 0, 0, sa);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      set_data(64'h3100 + 64'(i), 1'b0, 5'd10, 5'b00011);
      step(1, 0, 0, 0, sa);
      acc_cnt += int'(sa);
    end
    check_eq("t4_stall_accepts", 32'(acc_cnt), SKID ? 32'd1 : 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, sa);

    // Refill (skid full in that build), then flush alongside an offered entry
    set_data(64'h4000, 1'b1, 5'd4, 5'b10001);
    step(1, 1, 0, 0, sa);
    set_data(64'h4004, 1'b1, 5'd5, 5'b10001);
    step(1, 0, 0, 0, sa);
    step(1, 0, 0, 0, sa);
    set_data(64'h4008, 1'b0, 5'd6, 5'b00001);
    step(1, 1, 1, 0, sa);
    check_eq("t5_valid", bus.out_valid, 1'b0);
    check_eq("t5_in_ready", bus.in_ready, 1'b1);
    check_eq("t5_br", bus.out_br_taken, 1'b0);
    step(0, 1, 0, 0, sa);

    // Reset mid-stall with entries held
    set_data(64'h5000, 1'b1, 5'd8, 5'b11111);
    step(1, 1, 0, 0, sa);
    set_data(64'h5004, 1'b0, 5'd8, 5'b01111);
    step(1, 0, 0, 0, sa);
    step(0, 0, 0, 1, sa);
    check_eq("t6_valid", bus.out_valid, 1'b0);
    check_eq("t6_r", bus.out_r, 64'h0);
    check_eq("t6_br", bus.out_br_taken, 1'b0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      set_data({$urandom, $urandom}, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 499) == 0), sa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
